fft_peak_index_param: RTL and testbench

//  Parametrised successor to the fixed 8-bit FFT max-index detector.

---
 rtl/fft_peak_pkg.sv | 18 +
 rtl/fft_mag_sq.sv | 84 ++++++++
 rtl/fft_peak_index_param.sv | 226 ++++++++++++++++++++++
 tb/tb_fft_peak_index_param.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_peak_pkg.sv
// Shared types and constants for the FFT peak-index detector.
package fft_peak_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FLUSH,
        REPORT
    } state_t;

    localparam logic MODE_PEAK   = 1'b0;
    localparam logic MODE_THRESH = 1'b1;

    function automatic int mag_w(input int data_w);
        return 2 * data_w + 1;
    endfunction

endpackage

// File: rtl/fft_mag_sq.sv
// Two-stage |X|^2 pipeline: squares, then sum. Bin index, eligibility and
// start-of-frame travel alongside the magnitude so the compare stage sees them together.
module fft_mag_sq
    import fft_peak_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int INDEX_W = 8,
    parameter int MAG_W   = mag_w(DATA_W)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_vld,
    input  logic                      i_sop,
    input  logic                      i_elig,
    input  logic [INDEX_W-1:0]        i_idx,
    input  logic signed [DATA_W-1:0]  i_re,
    input  logic signed [DATA_W-1:0]  i_im,
    output logic                      o_vld,
    output logic                      o_sop,
    output logic                      o_elig,
    output logic [INDEX_W-1:0]        o_idx,
    output logic [MAG_W-1:0]          o_mag
);

    localparam int SQ_W = 2 * DATA_W;

    logic signed [SQ_W-1:0] w_re_ext;
    logic signed [SQ_W-1:0] w_im_ext;
    logic signed [SQ_W-1:0] w_re_sq;
    logic signed [SQ_W-1:0] w_im_sq;

    logic                   r_vld_p1;
    logic                   r_sop_p1;
    logic                   r_elig_p1;
    logic [INDEX_W-1:0]     r_idx_p1;
    logic [SQ_W-1:0]        r_re_sq_p1;
    logic [SQ_W-1:0]        r_im_sq_p1;

    logic                   r_vld_p2;
    logic                   r_sop_p2;
    logic                   r_elig_p2;
    logic [INDEX_W-1:0]     r_idx_p2;
    logic [MAG_W-1:0]       r_mag_p2;

    // A square is never negative, so each fits unsigned in SQ_W bits (max 2^(2*DATA_W-2)).
    assign w_re_ext = SQ_W'(i_re);
    assign w_im_ext = SQ_W'(i_im);
    assign w_re_sq  = w_re_ext * w_re_ext;
    assign w_im_sq  = w_im_ext * w_im_ext;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else begin
            r_vld_p1 <= i_vld;
            r_vld_p2 <= r_vld_p1;
        end
    end

    // p1: squares
    always_ff @(posedge i_clk) begin
        r_sop_p1   <= i_sop;
        r_elig_p1  <= i_elig;
        r_idx_p1   <= i_idx;
        r_re_sq_p1 <= $unsigned(w_re_sq);
        r_im_sq_p1 <= $unsigned(w_im_sq);
    end

    // p2: sum
    always_ff @(posedge i_clk) begin
        r_sop_p2  <= r_sop_p1;
        r_elig_p2 <= r_elig_p1;
        r_idx_p2  <= r_idx_p1;
        r_mag_p2  <= MAG_W'(r_re_sq_p1) + MAG_W'(r_im_sq_p1);
    end

    assign o_vld  = r_vld_p2;
    assign o_sop  = r_sop_p2;
    assign o_elig = r_elig_p2;
    assign o_idx  = r_idx_p2;
    assign o_mag  = r_mag_p2;

endmodule

// File: rtl/fft_peak_index_param.sv
// Per-frame peak (or first-over-threshold) bin detector on the FFT output stream.
// FSM and bin counter, |X|^2 pipeline instance, running best, and registered report outputs.
module fft_peak_index_param
    import fft_peak_pkg::*;
#(
    parameter int FFT_LEN   = 256,
    parameter int DATA_W    = 16,
    parameter int INDEX_W   = $clog2(FFT_LEN),
    parameter int SKIP_DC   = 1,
    parameter int HALF_SPEC = 1
) (
    input  logic                      clk_clk,
    input  logic                      reset_reset_n,
    input  logic                      sink_valid,
    output logic                      sink_ready,
    input  logic                      sink_sop,
    input  logic                      sink_eop,
    input  logic signed [DATA_W-1:0]  sink_real,
    input  logic signed [DATA_W-1:0]  sink_imag,
    input  logic                      mode_in,
    input  logic [2*DATA_W:0]         threshold_in,
    output logic                      result_valid,
    output logic [INDEX_W-1:0]        peak_index,
    output logic [2*DATA_W:0]         peak_mag,
    output logic                      peak_found,
    output logic                      frame_err,
    output logic [7:0]                index_byte
);

    localparam int MAG_W = mag_w(DATA_W);

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_run;
    logic [INDEX_W-1:0]   r_bin_cnt;
    logic [INDEX_W-1:0]   w_bin_next;
    logic                 r_flush_cnt;
    logic                 w_flush_next;
    logic                 r_err_pend;
    logic                 w_err_next;
    logic                 w_latch;
    logic                 r_mode;
    logic [MAG_W-1:0]     r_thr;

    logic                 w_accept;
    logic                 w_take;
    logic [INDEX_W-1:0]   w_beat_idx;
    logic                 w_last;
    logic                 w_frame_err;
    logic                 w_elig;

    logic                 w_s2_vld;
    logic                 w_s2_sop;
    logic                 w_s2_elig;
    logic [INDEX_W-1:0]   w_s2_idx;
    logic [MAG_W-1:0]     w_s2_mag;

    logic [INDEX_W-1:0]   r_best_idx;
    logic [MAG_W-1:0]     r_best_mag;
    logic                 r_best_hit;
    logic [INDEX_W-1:0]   w_best_idx_nxt;
    logic [MAG_W-1:0]     w_best_mag_nxt;
    logic                 w_best_hit_nxt;

    logic                 r_result_valid;
    logic [INDEX_W-1:0]   r_peak_index;
    logic [MAG_W-1:0]     r_peak_mag;
    logic                 r_peak_found;
    logic                 r_frame_err;

    // r_run keeps ready low while reset is held and for the first clock after release.
    assign sink_ready  = r_run && (r_state != FLUSH);
    assign w_accept    = sink_valid && sink_ready;
    assign w_take      = w_accept && (sink_sop || (r_state == SCAN));
    assign w_beat_idx  = ((r_state == SCAN) && !sink_sop) ? r_bin_cnt + 1'b1 : '0;
    assign w_last      = sink_eop || (w_beat_idx == INDEX_W'(FFT_LEN - 1));
    assign w_frame_err = (w_beat_idx != INDEX_W'(FFT_LEN - 1)) || !sink_eop;
    assign w_elig      = !((SKIP_DC != 0) && (w_beat_idx == '0)) &&
                         !((HALF_SPEC != 0) && (int'(w_beat_idx) >= FFT_LEN / 2));

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state     <= IDLE;
            r_run       <= 1'b0;
            r_bin_cnt   <= '0;
            r_flush_cnt <= 1'b0;
            r_err_pend  <= 1'b0;
            r_mode      <= MODE_PEAK;
            r_thr       <= '0;
        end else begin
            r_state     <= w_state_next;
            r_run       <= 1'b1;
            r_bin_cnt   <= w_bin_next;
            r_flush_cnt <= w_flush_next;
            r_err_pend  <= w_err_next;
            if (w_latch) begin
                r_mode <= mode_in;
                r_thr  <= threshold_in;
            end
        end
    end

    // REPORT also accepts a new sop so back-to-back frames lose no beat.
    always_comb begin
        w_state_next = r_state;
        w_bin_next   = r_bin_cnt;
        w_flush_next = 1'b0;
        w_err_next   = r_err_pend;
        w_latch      = 1'b0;
        unique case (r_state)
            FLUSH: begin
                w_flush_next = 1'b1;
                if (r_flush_cnt) begin
                    w_state_next = REPORT;
                end
            end
            default: begin
                if (w_take) begin
                    w_bin_next = w_beat_idx;
                    w_latch    = sink_sop;
                    if (w_last) begin
                        w_state_next = FLUSH;
                        w_err_next   = w_frame_err;
                    end else begin
                        w_state_next = SCAN;
                    end
                end else if (r_state == REPORT) begin
                    w_state_next = IDLE;
                end
            end
        endcase
    end

    fft_mag_sq #(
        .DATA_W  (DATA_W),
        .INDEX_W (INDEX_W),
        .MAG_W   (MAG_W)
    ) u_mag_sq (
        .i_clk   (clk_clk),
        .i_rst_n (reset_reset_n),
        .i_vld   (w_take),
        .i_sop   (sink_sop),
        .i_elig  (w_elig),
        .i_idx   (w_beat_idx),
        .i_re    (sink_real),
        .i_im    (sink_imag),
        .o_vld   (w_s2_vld),
        .o_sop   (w_s2_sop),
        .o_elig  (w_s2_elig),
        .o_idx   (w_s2_idx),
        .o_mag   (w_s2_mag)
    );

    // Running best restarts when the sop bin reaches this stage, so bins of an
    // abandoned frame still in flight are wiped by the restart.
    always_comb begin
        w_best_idx_nxt = r_best_idx;
        w_best_mag_nxt = r_best_mag;
        w_best_hit_nxt = r_best_hit;
        if (w_s2_vld && w_s2_sop) begin
            w_best_idx_nxt = '0;
            w_best_mag_nxt = '0;
            w_best_hit_nxt = 1'b0;
        end
        if (w_s2_vld && w_s2_elig) begin
            if (r_mode == MODE_PEAK) begin
                if (w_s2_mag > w_best_mag_nxt) begin
                    w_best_idx_nxt = w_s2_idx;
                    w_best_mag_nxt = w_s2_mag;
                end
            end else if (!w_best_hit_nxt && (w_s2_mag >= r_thr)) begin
                w_best_idx_nxt = w_s2_idx;
                w_best_mag_nxt = w_s2_mag;
                w_best_hit_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_best_idx <= '0;
            r_best_mag <= '0;
            r_best_hit <= 1'b0;
        end else begin
            r_best_idx <= w_best_idx_nxt;
            r_best_mag <= w_best_mag_nxt;
            r_best_hit <= w_best_hit_nxt;
        end
    end

    // The last bin sits in the sum stage during the second FLUSH cycle, so the
    // combinational best already includes it when the report is loaded.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_result_valid <= 1'b0;
            r_peak_index   <= '0;
            r_peak_mag     <= '0;
            r_peak_found   <= 1'b0;
            r_frame_err    <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            if ((r_state == FLUSH) && r_flush_cnt) begin
                r_result_valid <= 1'b1;
                r_peak_index   <= w_best_idx_nxt;
                r_peak_mag     <= w_best_mag_nxt;
                r_peak_found   <= (r_mode == MODE_PEAK) ? 1'b1 : w_best_hit_nxt;
                r_frame_err    <= r_err_pend;
            end
        end
    end

    assign result_valid = r_result_valid;
    assign peak_index   = r_peak_index;
    assign peak_mag     = r_peak_mag;
    assign peak_found   = r_peak_found;
    assign frame_err    = r_frame_err;

    generate
        if (INDEX_W >= 8) begin : g_byte_msb
            assign index_byte = r_peak_index[INDEX_W-1 -: 8];
        end else begin : g_byte_ext
            assign index_byte = {{(8 - INDEX_W){1'b0}}, r_peak_index};
        end
    endgenerate

endmodule

// File: tb/tb_fft_peak_index_param.sv
// Directed bench for fft_peak_index_param (FFT_LEN=16): frame-level model plus per-cycle compare.
module tb_fft_peak_index_param;

    localparam int N  = 16;
    localparam int DW = 16;
    localparam int IW = 4;
    localparam int MW = 2 * DW + 1;

    logic                  clk_clk = 1'b0;
    logic                  reset_reset_n = 1'b0;
    logic                  sink_valid = 1'b0;
    logic                  sink_ready;
    logic                  sink_sop = 1'b0;
    logic                  sink_eop = 1'b0;
    logic signed [DW-1:0]  sink_real = '0;
    logic signed [DW-1:0]  sink_imag = '0;
    logic                  mode_in = 1'b0;
    logic [MW-1:0]         threshold_in = '0;
    logic                  result_valid;
    logic [IW-1:0]         peak_index;
    logic [MW-1:0]         peak_mag;
    logic                  peak_found;
    logic                  frame_err;
    logic [7:0]            index_byte;

    fft_peak_index_param #(
        .FFT_LEN(N), .DATA_W(DW), .INDEX_W(IW), .SKIP_DC(1), .HALF_SPEC(1)
    ) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .sink_valid(sink_valid), .sink_ready(sink_ready),
        .sink_sop(sink_sop), .sink_eop(sink_eop),
        .sink_real(sink_real), .sink_imag(sink_imag),
        .mode_in(mode_in), .threshold_in(threshold_in),
        .result_valid(result_valid), .peak_index(peak_index), .peak_mag(peak_mag),
        .peak_found(peak_found), .frame_err(frame_err), .index_byte(index_byte)
    );

    always #5 clk_clk = ~clk_clk;

    int cyc = 0;
    always @(posedge clk_clk) cyc <= cyc + 1;

    typedef struct {
        int     cyc;
        int     idx;
        longint mag;
        bit     found;
        bit     err;
    } exp_t;

    exp_t exp_q[$];
    exp_t last;
    int   fr_re[N];
    int   fr_im[N];
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, got, want);
        end
    endtask

    // Frame-level reference: scan the bins the frame carried and apply the selection rule.
    function automatic exp_t model(input int n, input bit eop_end, input bit mode, input longint thr);
        exp_t e;
        longint m;
        e = '{cyc: 0, idx: 0, mag: 0, found: (mode == 1'b0), err: 0};
        for (int k = 0; k < n; k++) begin
            if (k == 0 || k >= N / 2) continue;
            m = longint'(fr_re[k]) * fr_re[k] + longint'(fr_im[k]) * fr_im[k];
            if (mode == 1'b0) begin
                if (m > e.mag) begin e.mag = m; e.idx = k; end
            end else if (!e.found && m >= thr) begin
                e.found = 1'b1; e.mag = m; e.idx = k;
            end
        end
        e.err = (n != N) || !eop_end;
        return e;
    endfunction

    task automatic clr(input int re, input int im);
        for (int k = 0; k < N; k++) begin fr_re[k] = re; fr_im[k] = im; end
    endtask

    // Called on a negedge; returns on the negedge after the beat is taken.
    task automatic drive_beat(input int re, input int im, input bit sop, input bit eop, output int acc_cyc);
        int tries = 0;
        sink_valid = 1'b1; sink_sop = sop; sink_eop = eop;
        sink_real = DW'(re); sink_imag = DW'(im);
        while (!sink_ready && tries < 20) begin @(negedge clk_clk); tries++; end
        if (!sink_ready) begin
            checks++; errors++;
            $display("FAIL beat_accept at cycle %0d: ready stayed 0, required 1", cyc);
        end
        acc_cyc = cyc;
        @(negedge clk_clk);
        sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit eop_end, input bit mode, input longint thr);
        int   c;
        exp_t e;
        mode_in = mode; threshold_in = MW'(thr);
        for (int k = 0; k < n; k++) begin
            drive_beat(fr_re[k], fr_im[k], k == 0, eop_end && (k == n - 1), c);
            if (k == 0) begin mode_in = !mode; threshold_in = '0; end
        end
        e = model(n, eop_end, mode, thr);
        e.cyc = c + 3;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    task automatic lit(input string tag, input int idx, input longint mag, input bit found, input bit err);
        chk({tag, "_index"}, 64'(peak_index), 64'(idx));
        chk({tag, "_mag"}, 64'(peak_mag), 64'(mag));
        chk({tag, "_found"}, 64'(peak_found), 64'(found));
        chk({tag, "_err"}, 64'(frame_err), 64'(err));
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_ready"}, 64'(sink_ready), 64'(0));
        chk({tag, "_valid"}, 64'(result_valid), 64'(0));
        chk({tag, "_index"}, 64'(peak_index), 64'(0));
        chk({tag, "_mag"}, 64'(peak_mag), 64'(0));
        chk({tag, "_found"}, 64'(peak_found), 64'(0));
        chk({tag, "_err"}, 64'(frame_err), 64'(0));
        chk({tag, "_byte"}, 64'(index_byte), 64'(0));
    endtask

    // Every cycle: pulse exactly when the model says, outputs equal the latest report.
    task automatic compare_cycle();
        bit due;
        due = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        chk("result_valid", 64'(result_valid), 64'(due));
        if (due) last = exp_q.pop_front();
        chk("peak_index", 64'(peak_index), 64'(last.idx));
        chk("peak_mag", 64'(peak_mag), 64'(last.mag));
        chk("peak_found", 64'(peak_found), 64'(last.found));
        chk("frame_err", 64'(frame_err), 64'(last.err));
        chk("index_byte", 64'(index_byte), 64'(last.idx));
    endtask

    task automatic run_tests();
        int c;
        idle(3);
        all_zero("reset");
        reset_reset_n = 1'b1;
        idle(1);
        chk("ready_after_reset", 64'(sink_ready), 64'(1));
        chk_en = 1'b1;

        // Mode 0 basic peak
        clr(10, 0); fr_re[5] = 300; fr_im[5] = 400;
        send_frame(N, 1, 0, 0);
        idle(5); lit("m0_basic", 5, 250000, 1, 0);

        // Tie keeps lowest index; DC and upper half ignored
        clr(0, 0); fr_re[0] = 1000; fr_re[3] = 50; fr_im[3] = 50;
        fr_re[6] = 50; fr_im[6] = 50; fr_re[9] = 900;
        send_frame(N, 1, 0, 0);
        idle(5); lit("m0_tie", 3, 5000, 1, 0);

        // Mode 1 first over threshold, then unreachable threshold
        clr(0, 0); fr_re[2] = 100; fr_re[4] = 150; fr_re[7] = 200;
        send_frame(N, 1, 1, 20000);
        idle(5); lit("m1_hit", 4, 22500, 1, 0);
        send_frame(N, 1, 1, 1000000000);
        idle(5); lit("m1_miss", 0, 0, 0, 0);

        // Full-scale negative inputs: magnitude needs the top bit
        clr(0, 0); fr_re[3] = 32767; fr_re[6] = -32768; fr_im[6] = -32768;
        send_frame(N, 1, 0, 0);
        idle(5); lit("m0_fullscale", 6, 64'd2147483648, 1, 0);

        // Only ineligible bins carry energy
        clr(0, 0); fr_re[0] = 500; fr_re[12] = 600;
        send_frame(N, 1, 0, 0);
        idle(5); lit("m0_inelig", 0, 0, 1, 0);

        // Short frame, then a good one; missing eop on a full frame
        clr(10, 0); fr_re[5] = 300; fr_im[5] = 400;
        send_frame(10, 1, 0, 0);
        idle(5); lit("short", 5, 250000, 1, 1);
        send_frame(N, 1, 0, 0);
        idle(5); lit("after_short", 5, 250000, 1, 0);
        send_frame(N, 0, 0, 0);
        idle(5); lit("no_eop", 5, 250000, 1, 1);

        // Non-sop beats in IDLE are dropped, even a full run ending in eop
        for (int k = 0; k < N; k++) drive_beat(30000, 0, 1'b0, k == N - 1, c);
        idle(6);

        // sop in SCAN abandons the partial frame
        clr(0, 0); fr_re[2] = 3000;
        for (int k = 0; k < 4; k++) drive_beat(fr_re[k], fr_im[k], k == 0, 1'b0, c);
        clr(0, 0); fr_re[7] = 20;
        send_frame(N, 1, 0, 0);
        idle(5); lit("restart", 7, 400, 1, 0);

        // Handshake: ready low for exactly two cycles after eop; offered beat not consumed
        clr(10, 0); fr_re[3] = 20;
        send_frame(N, 1, 0, 0);
        chk("flush_ready1", 64'(sink_ready), 64'(0));
        sink_valid = 1'b1; sink_sop = 1'b1; sink_eop = 1'b1; sink_real = 16'sd7000;
        idle(1);
        chk("flush_ready2", 64'(sink_ready), 64'(0));
        idle(1);
        sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
        chk("report_ready", 64'(sink_ready), 64'(1));
        idle(5); lit("handshake", 3, 400, 1, 0);

        // Asynchronous reset in the middle of a frame
        clr(10, 0); fr_re[5] = 300; fr_im[5] = 400;
        for (int k = 0; k < 8; k++) drive_beat(fr_re[k], fr_im[k], k == 0, 1'b0, c);
        chk_en = 1'b0;
        reset_reset_n = 1'b0;
        #1;
        all_zero("mid_reset");
        idle(2);
        reset_reset_n = 1'b1;
        last = '{cyc: 0, idx: 0, mag: 0, found: 0, err: 0};
        idle(1);
        chk_en = 1'b1;
        idle(8);
        send_frame(N, 1, 0, 0);
        idle(5); lit("post_reset", 5, 250000, 1, 0);

        idle(4);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_results: %0d reports still expected, required 0", exp_q.size());
        end
    endtask

    initial begin
        last = '{cyc: 0, idx: 0, mag: 0, found: 0, err: 0};
        fork
            begin : cmp
                forever begin
                    @(negedge clk_clk);
                    if (chk_en) compare_cycle();
                end
            end
            begin : stim
                run_tests();
            end
        join_any
        disable fork;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
